// File: rtl/render_pkg.sv
// Shared types and helpers for the renderer's SDRAM read path.
package render_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rm_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Byte length to whole words, rounding up; 33-bit sum so 0xFFFFFFFD+ cannot wrap.
    function automatic logic [30:0] ceil_words(input logic [31:0] len);
        return 31'(({1'b0, len} + 33'd3) >> 2);
    endfunction

endpackage

// File: rtl/avalon_read_master_if.sv
// Avalon-MM read bus plus the downstream word stream of the read master.
interface avalon_read_master_if #(parameter int DATA_W = 32);

    logic [31:0]       avm_address;
    logic              avm_read;
    logic [3:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output rd_data, rd_valid,
        input  rd_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  rd_data, rd_valid,
        output rd_ready
    );

endinterface

// File: rtl/avalon_read_master_rm_sync_fifo.sv
// Return-data FIFO: single clock, head word visible combinationally on rd_data.
module rm_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, do_wr, do_rd;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/avalon_read_master.sv
// Byte-length read requests -> Avalon-MM burst reads -> buffered valid/ready word stream.
// Optional RM_STATS_EN adds stall_cycles / xfer_cycles performance counters.
module avalon_read_master
    import render_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BURST_MAX  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_read,
    input  logic [31:0]                 length_read,
    input  logic [31:0]                 RM_startaddress,
    output logic                        RM_done,
    avalon_read_master_if.master        bus
`ifdef RM_STATS_EN
    , output logic [31:0]               stall_cycles
    , output logic [31:0]               xfer_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;

    rm_state_t       state, state_n;
    logic [31:0]     addr;
    logic [30:0]     words_left;
    logic [CW-1:0]   outstanding, fifo_count;
    logic            fifo_empty;
    logic [BW-1:0]   burst;
    logic [CW:0]     credit;
    logic            can_issue, accept, beat, pop, latch;

    assign latch  = (state == IDLE) && start_read;
    assign burst  = (words_left >= 31'(BURST_MAX)) ? BW'(BURST_MAX) : words_left[BW-1:0];
    // Free slots not already promised to bursts in flight; never negative.
    assign credit = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, outstanding};
    assign can_issue = (state == ISSUE) && (credit >= (CW+1)'(burst));
    assign accept = bus.avm_read && !bus.avm_waitrequest;
    // Beats with nothing outstanding are stale returns from before a reset.
    assign beat   = bus.avm_readdatavalid && (outstanding != '0);
    assign pop    = bus.rd_valid && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_read) state_n = (ceil_words(length_read) == '0) ? DONE : ISSUE;
            ISSUE: if (accept && (words_left == 31'(burst))) state_n = DRAIN;
            DRAIN: if ((outstanding == '0) && fifo_empty) state_n = DONE;
            DONE:  if (!start_read) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command is a function of registered state only, so it holds steady under waitrequest.
    always_comb begin
        bus.avm_read       = can_issue;
        bus.avm_burstcount = can_issue ? 4'(burst) : 4'd0;
        RM_done            = (state == DONE);
    end

    assign bus.avm_address = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            words_left  <= '0;
            outstanding <= '0;
        end else begin
            if (latch) begin
                addr       <= RM_startaddress & ~32'd3;
                words_left <= ceil_words(length_read);
            end else if (accept) begin
                addr       <= addr + 32'(burst) * 32'(BYTES_PER_WORD);
                words_left <= words_left - 31'(burst);
            end
            outstanding <= outstanding + (accept ? CW'(burst) : CW'(0)) - (beat ? CW'(1) : CW'(0));
        end
    end

    rm_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat),
        .wr_data (bus.avm_readdata),
        .rd_en   (pop),
        .rd_data (bus.rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.rd_valid = !fifo_empty;

`ifdef RM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || latch) begin
            stall_cycles <= '0;
            xfer_cycles  <= '0;
        end else begin
            if (bus.avm_read && bus.avm_waitrequest && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if ((state == ISSUE) || (state == DRAIN))
                xfer_cycles <= xfer_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_read_master.sv
// Self-checking bench: Avalon slave model, stream consumer, reference word/burst model.
module tb_avalon_read_master;

    localparam int DATA_W     = 32;
    localparam int BURST_MAX  = 8;
    localparam int FIFO_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_read = 1'b0;
    logic [31:0] length_read = '0;
    logic [31:0] RM_startaddress = '0;
    logic        RM_done;
`ifdef RM_STATS_EN
    logic [31:0] stall_cycles, xfer_cycles;
`endif

    avalon_read_master_if #(.DATA_W(DATA_W)) bus ();

    avalon_read_master #(
        .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_read      (start_read),
        .length_read     (length_read),
        .RM_startaddress (RM_startaddress),
        .RM_done         (RM_done),
        .bus             (bus.master)
`ifdef RM_STATS_EN
        , .stall_cycles  (stall_cycles)
        , .xfer_cycles   (xfer_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [3:0] bc; } cmd_t;

    int n_checks = 0, n_fail = 0;
    cmd_t        cmds[$], exp_cmds[$];
    logic [31:0] beats[$], got[$], exp_words[$];
    int  stall_budget = 0, stall_seen = 0, stable_viol = 0;
    int  occ = 0, max_occ = 0, ready_mode = 1;
    bit  wait_rand = 0, ret_rand = 0, drop_beats = 0, held_v = 0;
    cmd_t held;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Observe the bus at the active edge (pre-update values).
    always @(posedge clk) begin
        if (rst) begin
            held_v = 0;
            occ    = 0;
        end else begin
            if (held_v && !(bus.avm_read && bus.avm_address == held.a && bus.avm_burstcount == held.bc))
                stable_viol++;
            held_v  = bus.avm_read && bus.avm_waitrequest;
            held.a  = bus.avm_address;
            held.bc = bus.avm_burstcount;
            if (bus.avm_read && bus.avm_waitrequest) begin
                stall_seen++;
                if (stall_budget > 0) stall_budget--;
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                cmds.push_back(held);
                for (int i = 0; i < int'(bus.avm_burstcount); i++)
                    beats.push_back(bus.avm_address + 32'(i) * 32'd4);
            end
            if (bus.avm_readdatavalid && !drop_beats) occ++;
            if (bus.rd_valid && bus.rd_ready) begin
                got.push_back(bus.rd_data);
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
        end
    end

    // Drive slave responses and consumer ready away from the edge.
    always @(negedge clk) begin
        bus.avm_waitrequest = (stall_budget > 0) || (wait_rand && $urandom_range(0, 3) == 0);
        if (beats.size() > 0 && (!ret_rand || $urandom_range(0, 2) != 0)) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = mem_word(beats.pop_front());
        end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = $urandom;
        end
        bus.rd_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
    end

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] len);
        longint unsigned nw, rem;
        logic [31:0] ca;
        cmd_t c;
        exp_words.delete(); exp_cmds.delete(); cmds.delete(); got.delete();
        max_occ = 0;
        nw = ({32'd0, len} + 64'd3) >> 2;
        ca = {a[31:2], 2'b00};
        for (longint unsigned i = 0; i < nw; i++) exp_words.push_back(mem_word(ca + 32'(i * 4)));
        rem = nw;
        while (rem > 0) begin
            c.a  = ca;
            c.bc = (rem >= BURST_MAX) ? 4'(BURST_MAX) : 4'(rem);
            exp_cmds.push_back(c);
            ca  += 32'(c.bc) * 32'd4;
            rem -= 64'(c.bc);
        end
        @(negedge clk);
        RM_startaddress = a;
        length_read     = len;
        start_read      = 1'b1;
    endtask

    task automatic check_xfer(input string name);
        int cyc = 0, bad = 0;
        while (!RM_done && cyc < 20000) begin @(negedge clk); cyc++; end
        n_checks++;
        if (RM_done !== 1'b1) begin
            n_fail++; $display("FAIL %s done: RM_done=%b after %0d cycles, required 1", name, RM_done, cyc);
        end
        n_checks++;
        if (got.size() != exp_words.size()) begin
            n_fail++; $display("FAIL %s word_count: got %0d words at done, required %0d", name, got.size(), exp_words.size());
        end
        for (int i = 0; i < got.size() && i < exp_words.size(); i++)
            if (got[i] !== exp_words[i]) begin
                if (bad == 0) $display("FAIL %s word[%0d]: got %h, required %h", name, i, got[i], exp_words[i]);
                bad++;
            end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL %s words: %0d wrong words, required 0", name, bad); end
        bad = (cmds.size() != exp_cmds.size()) ? 1 : 0;
        for (int i = 0; i < cmds.size() && i < exp_cmds.size(); i++)
            if (cmds[i] !== exp_cmds[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL %s bursts: %0d bursts (first %h/%0d), required %0d (first %h/%0d)", name,
                cmds.size(), cmds.size() > 0 ? cmds[0].a : 32'd0, cmds.size() > 0 ? cmds[0].bc : 4'd0,
                exp_cmds.size(), exp_cmds.size() > 0 ? exp_cmds[0].a : 32'd0, exp_cmds.size() > 0 ? exp_cmds[0].bc : 4'd0);
        end
        n_checks++;
        if (max_occ > FIFO_DEPTH) begin
            n_fail++; $display("FAIL %s occupancy: peak %0d words, required <= %0d", name, max_occ, FIFO_DEPTH);
        end
    endtask

    task automatic drop_start(input string name);
        @(negedge clk);
        start_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (RM_done !== 1'b0) begin n_fail++; $display("FAIL %s done_drop: RM_done=%b, required 0", name, RM_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({RM_done, bus.avm_read, bus.avm_address, bus.avm_burstcount, bus.rd_valid} !== '0) begin
            n_fail++; $display("FAIL reset outputs: done=%b read=%b addr=%h bc=%0d valid=%b, required all 0",
                RM_done, bus.avm_read, bus.avm_address, bus.avm_burstcount, bus.rd_valid);
        end
`ifdef RM_STATS_EN
        n_checks++;
        if ({stall_cycles, xfer_cycles} !== '0) begin
            n_fail++; $display("FAIL reset stats: stall=%0d xfer=%0d, required 0", stall_cycles, xfer_cycles);
        end
`endif
    endtask

    task automatic test_lookat();
        ready_mode = 1;
        start_xfer(32'h1000, 32'd48);
        check_xfer("lookat");
        drop_start("lookat");
    endtask

    task automatic test_stall();
        stall_seen = 0; stable_viol = 0; stall_budget = 5;
        start_xfer(32'h1000, 32'd32);
        check_xfer("stall");
        n_checks++;
        if (stall_seen != 5) begin n_fail++; $display("FAIL stall count: %0d stalled cycles, required 5", stall_seen); end
        n_checks++;
        if (stable_viol != 0) begin n_fail++; $display("FAIL stall hold: %0d unstable commands, required 0", stable_viol); end
`ifdef RM_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stall stats: stall_cycles=%0d, required 5", stall_cycles); end
`endif
        drop_start("stall");
    endtask

    task automatic test_backpressure();
        ready_mode = 0;
        start_xfer(32'h4000, 32'd256);
        repeat (80) @(negedge clk);
        n_checks++;
        if (cmds.size() != 4 || bus.avm_read !== 1'b0) begin
            n_fail++; $display("FAIL bp credit: %0d bursts, read=%b, required 4 bursts and read 0", cmds.size(), bus.avm_read);
        end
        ready_mode = 1;
        check_xfer("bp");
        drop_start("bp");
    endtask

    task automatic test_odd_zero();
        ready_mode = 2; ret_rand = 1;
        start_xfer(32'h6002, 32'd10);
        check_xfer("odd");
        drop_start("odd");
        cmds.delete();
        @(negedge clk);
        length_read = 32'd0; RM_startaddress = 32'h7000; start_read = 1'b1;
        @(negedge clk);
        n_checks++;
        if (RM_done !== 1'b1 || cmds.size() != 0) begin
            n_fail++; $display("FAIL zero len: RM_done=%b bursts=%0d, required 1 and 0", RM_done, cmds.size());
        end
`ifdef RM_STATS_EN
        n_checks++;
        if (xfer_cycles !== 32'd0) begin n_fail++; $display("FAIL zero xfer: xfer_cycles=%0d, required 0", xfer_cycles); end
`endif
        drop_start("zero");
        ret_rand = 0;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        ready_mode = 0;
        start_xfer(32'h3000, 32'd128);
        while (cmds.size() < 2 && cyc < 200) begin @(negedge clk); cyc++; end
        rst = 1'b1; start_read = 1'b0;
        @(negedge clk);
        rst = 1'b0; drop_beats = 1;
        n_checks++;
        if ({RM_done, bus.avm_read, bus.avm_address, bus.avm_burstcount, bus.rd_valid} !== '0) begin
            n_fail++; $display("FAIL midrst outputs: done=%b read=%b addr=%h bc=%0d valid=%b, required all 0",
                RM_done, bus.avm_read, bus.avm_address, bus.avm_burstcount, bus.rd_valid);
        end
        cyc = 0;
        while (beats.size() > 0 && cyc < 200) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst stale: rd_valid=%b, required 0", bus.rd_valid); end
        drop_beats = 0; occ = 0; ready_mode = 1;
        start_xfer(32'h2000, 32'd16);
        check_xfer("after_rst");
        drop_start("after_rst");
    endtask

    task automatic test_level();
        int n0;
        start_xfer(32'h5000, 32'd20);
        check_xfer("level");
        n0 = cmds.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if (RM_done !== 1'b1 || cmds.size() != n0) begin
            n_fail++; $display("FAIL level hold: RM_done=%b bursts=%0d, required 1 and %0d", RM_done, cmds.size(), n0);
        end
        drop_start("level");
        start_xfer(32'h5100, 32'd12);
        check_xfer("relatch");
        drop_start("relatch");
    endtask

    task automatic test_random();
        wait_rand = 1; ret_rand = 1; ready_mode = 2; stable_viol = 0;
        for (int k = 0; k < 6; k++) begin
            start_xfer((k == 0) ? 32'hFFFF_FFF0 : $urandom, 32'($urandom_range(1, 300)));
            check_xfer("random");
            drop_start("random");
        end
        n_checks++;
        if (stable_viol != 0) begin n_fail++; $display("FAIL random hold: %0d unstable commands, required 0", stable_viol); end
        wait_rand = 0; ret_rand = 0; ready_mode = 1;
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata = '0; bus.rd_ready = 1'b1;
        test_reset();
        test_lookat();
        test_stall();
        test_backpressure();
        test_odd_zero();
        test_reset_mid();
        test_level();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
